hv_sched: RTL
=============

Name: hv_sched

Overview:
- Top-level sequencer for the hypervector datapath; replaces the fixed item count and address limits with values latched from configuration.
- Drives the gen phase (item-memory fill via PRNG, item_a address counter), then the run phase (stream ingest, encode, result stream-out).
- Detects completion and stalls, and exposes status for AXI-Lite readback.

Parameters:
ITEM_W, 16, width of item count / item_a address
ADDR_W, 20, width of addr_i / addr_j loop limits
TIMEOUT, 1000000, idle cycles in RUN/DRAIN before abort with error (fits 24 bits)

Ports:
clk  in  1  system clock (AXIS clock domain)
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse: begin job
abort  in  1  one-cycle pulse: cancel job
clear  in  1  one-cycle pulse: clear done/err
cfg_item_num  in  ITEM_W  items to generate
cfg_addr_i  in  ADDR_W  outer loop limit
cfg_addr_j  in  ADDR_W  inner loop limit
get_v  in  1  input stream beat accepted (progress)
get_fin  in  1  pulse: last input beat consumed, results final
out_hs  in  1  output beat handshake (TVALID&TREADY)
out_last  in  1  TLAST of current output beat
gen  out  1  item-memory generation enable
run  out  1  datapath run enable (deassert = datapath reset)
item_a  out  ITEM_W  item-memory write address
addr_i  out  ADDR_W  latched outer limit
addr_j  out  ADDR_W  latched inner limit
busy  out  1  state is GEN, RUN or DRAIN
done  out  1  sticky job complete
err  out  1  sticky error (zero items, timeout, abort)
state_o  out  3  encoded state for readback
cycle_cnt  out  32  cycles from start to done

Behaviour:
- States: IDLE=0, GEN=1, RUN=2, DRAIN=3, DONE=4.
- Reset: state IDLE; gen=run=busy=done=err=0; item_a, addr_i, addr_j, cycle_cnt, timeout counter = 0.
- IDLE:
  - start with cfg_item_num!=0 → latch cfg_addr_i/j; clear done, err, cycle_cnt; go GEN.
  - start with cfg_item_num==0 → err=1, stay IDLE.
- GEN:
  - gen=1; item_a starts at 0 on the first GEN cycle and increments 1 per cycle.
  - On the cycle item_a==cfg_item_num_latched-1 → next state RUN, gen=0, item_a holds the last value.
  - Exactly cfg_item_num cycles with gen=1.
- RUN: run=1. get_fin → DRAIN. get_fin together with out_hs&out_last in the same cycle → DONE directly.
- DRAIN: run=1; out_hs&out_last → DONE.
- DONE:
  - run=0, done=1. Stay until start (new job, same rules as IDLE) or clear (→IDLE, done=0).
  - start and clear in the same cycle: start wins.
- cycle_cnt:
  - Increments every cycle in GEN/RUN/DRAIN, holds in DONE/IDLE.
  - Wraps at 2^32 without flag.
- Timeout:
  - Counter active in RUN/DRAIN; resets to 0 on any cycle with get_v, get_fin or out_hs.
  - On reaching TIMEOUT → err=1, IDLE, gen=run=0.
- abort: in any busy state → IDLE next cycle, gen=run=0, err=1, done unchanged. In IDLE/DONE abort is ignored.
- Priority: rst > abort > timeout > normal transitions.
- start while busy: ignored.
- clear: clears err in any state; clears done only when not transitioning on start.
- Outputs are registered; gen/run change one cycle after the triggering input.
- addr_i/addr_j remain stable for the whole job; cfg changes mid-job have no effect.

Test Plan:
- rst, cfg_item_num=5, start → gen high for exactly 5 cycles, item_a 0..4, then run=1, busy=1, state_o=2.
- In RUN, pulse get_fin, 3 cycles later out_hs&out_last → DRAIN then DONE; done=1, run=0, cycle_cnt = 5+RUN+DRAIN cycles.
- cfg_item_num=0, start → err=1, gen never asserted, state_o=0; clear → err=0.
- TIMEOUT=16 override; in RUN hold get_v=get_fin=out_hs=0 → at the 16th idle cycle err=1, run=0, state_o=0. A get_v at cycle 10 restarts the count.
- abort during GEN at item_a=2 → next cycle gen=0, state_o=0, err=1; start during busy ignored (item_a sequence unaffected).
- get_fin and out_hs&out_last in the same RUN cycle → DONE directly, DRAIN never visited; start in DONE with new cfg_addr_i=149 → addr_i=149, done=0, new job runs.

Source files
------------

// File: rtl/hv_sched.sv
// hv_sched: job sequencer for the hypervector datapath.
// Item-memory fill, run/drain with idle timeout, status readback.
module hv_sched #(
  parameter int ITEM_W  = 16,
  parameter int ADDR_W  = 20,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              clear,
  input  logic [ITEM_W-1:0] cfg_item_num,
  input  logic [ADDR_W-1:0] cfg_addr_i,
  input  logic [ADDR_W-1:0] cfg_addr_j,
  input  logic              get_v,
  input  logic              get_fin,
  input  logic              out_hs,
  input  logic              out_last,
  output logic              gen,
  output logic              run,
  output logic [ITEM_W-1:0] item_a,
  output logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] addr_j,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        state_o,
  output logic [31:0]       cycle_cnt
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GEN   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [ITEM_W-1:0] num_q;
  logic [TO_W-1:0]   tcnt;
  logic              in_run;
  logic              busy_s;
  logic              act;
  logic              last_beat;
  logic              start_ok;
  logic              to_hit;
  logic              launch;
  logic              set_err;

  assign state_o = state;

  always_comb begin
    in_run    = (state == S_RUN) || (state == S_DRAIN);
    busy_s    = in_run || (state == S_GEN);
    act       = get_v | get_fin | out_hs;
    last_beat = out_hs & out_last;
    start_ok  = start && (cfg_item_num != '0);
    to_hit    = in_run && !act
             && (tcnt == TO_W'(TIMEOUT - 1));
    state_n   = state;
    launch    = 1'b0;
    set_err   = 1'b0;
    if (busy_s && abort) begin
      state_n = S_IDLE;
      set_err = 1'b1;
    end else if (to_hit) begin
      state_n = S_IDLE;
      set_err = 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_ok) begin
            launch  = 1'b1;
            state_n = S_GEN;
          end else if (start) begin
            set_err = 1'b1;
          end
        end
        S_GEN: begin
          if (item_a == num_q - 1'b1)
            state_n = S_RUN;
        end
        S_RUN: begin
          if (get_fin && last_beat)
            state_n = S_DONE;
          else if (get_fin)
            state_n = S_DRAIN;
        end
        S_DRAIN: begin
          if (last_beat)
            state_n = S_DONE;
        end
        S_DONE: begin
          // a valid start outranks clear
          if (start_ok) begin
            launch  = 1'b1;
            state_n = S_GEN;
          end else begin
            set_err = start;
            if (clear)
              state_n = S_IDLE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      gen       <= 1'b0;
      run       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      item_a    <= '0;
      num_q     <= '0;
      addr_i    <= '0;
      addr_j    <= '0;
      cycle_cnt <= '0;
      tcnt      <= '0;
    end else begin
      state <= state_n;
      gen   <= (state_n == S_GEN);
      run   <= (state_n == S_RUN)
            || (state_n == S_DRAIN);
      busy  <= (state_n == S_GEN)
            || (state_n == S_RUN)
            || (state_n == S_DRAIN);
      if (launch) begin
        num_q     <= cfg_item_num;
        addr_i    <= cfg_addr_i;
        addr_j    <= cfg_addr_j;
        item_a    <= '0;
        cycle_cnt <= '0;
      end else begin
        if (state == S_GEN && state_n == S_GEN)
          item_a <= item_a + 1'b1;
        if (busy_s)
          cycle_cnt <= cycle_cnt + 32'd1;
      end
      if (in_run && !act && !to_hit && !abort)
        tcnt <= tcnt + 1'b1;
      else
        tcnt <= '0;
      if (set_err)
        err <= 1'b1;
      else if (launch || clear)
        err <= 1'b0;
      if (launch)
        done <= 1'b0;
      else if (state_n == S_DONE && state != S_DONE)
        done <= 1'b1;
      else if (clear)
        done <= 1'b0;
    end
  end

endmodule
